// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int LANES = 4;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with per-byte-lane write enables.
// Read data is registered and reflects the write on the same edge (write-first).
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic [LANES-1:0]  i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [0:(1<<ADDR_W)-1];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        r_rdata[8*i +: 8] <= i_we[i] ? i_wdata[8*i +: 8] : r_mem[i_addr][8*i +: 8];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store, fixed wait states.
// Optional byte-lane store strobes are enabled with DMEM_BYTE_STROBE_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]  req_strb,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_write;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic              r_rsp_err;
  logic              r_rsp_load;

  logic              w_accept;
  logic              w_fire;
  logic              w_a_write;
  logic [31:0]       w_a_addr;
  logic [31:0]       w_a_wdata;
  logic [LANES-1:0]  w_a_strb;
  logic              w_a_err;
  logic              w_mem_en;
  logic [LANES-1:0]  w_mem_we;
  logic [31:0]       w_mem_rdata;

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'd0);
  endfunction

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign w_accept  = req_valid && req_ready;

  // With no wait states the access happens on the accepting edge, so it must
  // use the live request rather than the latched copy.
  assign w_fire    = ((r_state == WAIT) && (r_cnt == CNT_W'(1))) ||
                     (w_accept && (WAIT_CYCLES == 0));
  assign w_a_write = (WAIT_CYCLES == 0) ? req_write : r_write;
  assign w_a_addr  = (WAIT_CYCLES == 0) ? req_addr  : r_addr;
  assign w_a_wdata = (WAIT_CYCLES == 0) ? req_wdata : r_wdata;

`ifdef DMEM_BYTE_STROBE_EN
  logic [LANES-1:0] r_strb;

  always_ff @(posedge clk) begin
    if (w_accept) r_strb <= req_strb;
  end

  assign w_a_strb = (WAIT_CYCLES == 0) ? req_strb : r_strb;
`else
  assign w_a_strb = '1;
`endif

  assign w_a_err  = addr_err(w_a_addr);
  assign w_mem_en = w_fire && !w_a_err;
  assign w_mem_we = (w_mem_en && w_a_write) ? w_a_strb : '0;

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .i_en    (w_mem_en),
    .i_we    (w_mem_we),
    .i_addr  (w_a_addr[ADDR_W+1:2]),
    .i_wdata (w_a_wdata),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rsp_err  <= 1'b0;
      r_rsp_load <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid && (WAIT_CYCLES != 0)) begin
            r_state <= WAIT;
            r_cnt   <= CNT_W'(WAIT_CYCLES);
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
        RESP: begin
          if (rsp_ready) begin
            r_state    <= IDLE;
            r_rsp_err  <= 1'b0;
            r_rsp_load <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
      // Entering RESP overrides the per-state updates above.
      if (w_fire) begin
        r_state    <= RESP;
        r_rsp_err  <= w_a_err;
        r_rsp_load <= !w_a_write && !w_a_err;
      end
    end
  end

  // The RAM output register only changes on an access, so it holds through RESP.
  assign rsp_rdata = r_rsp_load ? w_mem_rdata : 32'd0;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic against a
// transaction-level model of the memory and handshake timing.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int AW = 10;
`ifdef DMEM_BYTE_STROBE_EN
  localparam int W = 0;
`else
  localparam int W = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_strb  (req_strb),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mem   [0:(1<<AW)-1];
  bit          known [0:(1<<AW)-1];
  bit          m_seen = 0;
  bit          m_busy = 0;
  int          m_t    = 0;
  logic        m_write;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_strb;
  logic        m_err;
  bit          m_rknown;

  task model_access();
    int idx;
    logic [31:0] w;
    m_err    = (m_addr[1:0] != 2'b00) || ((m_addr >> (AW + 2)) != 32'd0);
    m_rdata  = 32'd0;
    m_rknown = 1;
    if (!m_err) begin
      idx = int'(m_addr[AW+1:2]);
      if (m_write) begin
        w = mem[idx];
        for (int i = 0; i < 4; i++) if (m_strb[i]) w[8*i +: 8] = m_wdata[8*i +: 8];
        mem[idx] = w;
        if (m_strb == 4'hF) known[idx] = 1;
      end else begin
        m_rdata  = mem[idx];
        m_rknown = known[idx];
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      m_seen = 1;
      m_busy = 0;
      m_t    = 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy  = 1;
        m_t     = 1;
        m_write = req_write;
        m_addr  = req_addr;
        m_wdata = req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
        m_strb  = req_strb;
`else
        m_strb  = 4'hF;
`endif
        if (m_t == W + 1) model_access();
      end
    end else if (m_t >= W + 1) begin
      if (rsp_ready) m_busy = 0;
    end else begin
      m_t++;
      if (m_t == W + 1) model_access();
    end
  end

  always @(negedge clk) begin
    if (m_seen) begin
      check1("req_ready", req_ready, !m_busy);
      check1("rsp_valid", rsp_valid, m_busy && (m_t >= W + 1));
      if (m_busy && (m_t >= W + 1)) begin
        check1("rsp_err", rsp_err, m_err);
        if (m_rknown) check32("rsp_rdata", rsp_rdata, m_rdata);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit acc;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_strb  = s;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      acc = req_ready;
      step();
      if (acc) break;
    end
    req_valid = 1'b0;
    if (!acc) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: got no req_ready, expected acceptance within 40 cycles");
    end
  endtask

  task automatic get_rsp(input int hold, output logic [31:0] rd, output logic er, output int lat);
    bit got;
    rsp_ready = (hold == 0);
    lat = 1;
    got = 0;
    rd  = 32'hxxxx_xxxx;
    er  = 1'bx;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1;
        break;
      end
      step();
      lat++;
    end
    if (!got) begin
      n_vec++;
      n_bad++;
      $display("FAIL rsp_timeout: got no rsp_valid, expected one within 40 cycles");
      rsp_ready = 1'b0;
      step();
    end else begin
      rd = rsp_rdata;
      er = rsp_err;
      if (hold > 0) begin
        // A new request waits during back-pressure and must be ignored.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h30;
        for (int j = 0; j < hold; j++) begin
          step();
          if (j == hold - 1) begin
            rsp_ready = 1'b1;
            req_valid = 1'b0;
          end
        end
      end
      step();
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no $finish, expected completion before 500us");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] a;
    int          r;

    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_strb = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check1("reset_req_ready", req_ready, 1'b1);
    check1("reset_rsp_valid", rsp_valid, 1'b0);
    check32("reset_rsp_rdata", rsp_rdata, 32'd0);
    check1("reset_rsp_err", rsp_err, 1'b0);
    step();

    send(1'b1, 32'h0, 32'h1122_3344, 4'hF);
    get_rsp(0, rd, er, lat);

    send(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    get_rsp(0, rd, er, lat);
    check32("store_latency", 32'(lat), 32'(W + 1));
    check32("store_rdata", rd, 32'd0);
    check1("store_err", er, 1'b0);

    send(1'b0, 32'h10, 32'h0, 4'h0);
    get_rsp(0, rd, er, lat);
    check32("load_latency", 32'(lat), 32'(W + 1));
    check32("load_rdata", rd, 32'hDEAD_BEEF);
    check1("load_err", er, 1'b0);

    send(1'b0, 32'h6, 32'h0, 4'h0);
    get_rsp(0, rd, er, lat);
    check1("misaligned_err", er, 1'b1);
    check32("misaligned_rdata", rd, 32'd0);

    send(1'b0, 32'h1000, 32'h0, 4'h0);
    get_rsp(0, rd, er, lat);
    check1("range_err", er, 1'b1);
    check32("range_rdata", rd, 32'd0);

    send(1'b1, 32'h2, 32'hFFFF_FFFF, 4'hF);
    get_rsp(0, rd, er, lat);
    check1("bad_store_err", er, 1'b1);

    send(1'b0, 32'h0, 32'h0, 4'h0);
    get_rsp(0, rd, er, lat);
    check32("word0_unchanged", rd, 32'h1122_3344);

    send(1'b0, 32'h10, 32'h0, 4'h0);
    get_rsp(5, rd, er, lat);
    check32("backpressure_rdata", rd, 32'hDEAD_BEEF);
    @(negedge clk);
    check1("ready_after_handshake", req_ready, 1'b1);
    step();

    send(1'b1, 32'h20, 32'hCAFE_0001, 4'hF);
    get_rsp(0, rd, er, lat);
    send(1'b1, 32'h20, 32'hBAD0_0002, 4'hF);
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    check1("midreset_req_ready", req_ready, 1'b1);
    check1("midreset_rsp_valid", rsp_valid, 1'b0);
    check32("midreset_rsp_rdata", rsp_rdata, 32'd0);
    check1("midreset_rsp_err", rsp_err, 1'b0);
    step();
    send(1'b0, 32'h20, 32'h0, 4'h0);
    get_rsp(0, rd, er, lat);
    check32("midreset_load", rd, (W > 0) ? 32'hCAFE_0001 : 32'hBAD0_0002);

`ifdef DMEM_BYTE_STROBE_EN
    send(1'b1, 32'h0, 32'h1122_3344, 4'hF);
    get_rsp(0, rd, er, lat);
    send(1'b1, 32'h0, 32'hAABB_CCDD, 4'b0101);
    get_rsp(0, rd, er, lat);
    check32("strobe_latency", 32'(lat), 32'd1);
    send(1'b0, 32'h0, 32'h0, 4'h0);
    get_rsp(0, rd, er, lat);
    check32("strobe_merge", rd, 32'h11BB_33DD);
    send(1'b1, 32'h0, 32'hFFFF_FFFF, 4'h0);
    get_rsp(0, rd, er, lat);
    check1("strobe_zero_err", er, 1'b0);
    send(1'b0, 32'h0, 32'h0, 4'hF);
    get_rsp(0, rd, er, lat);
    check32("strobe_zero_noop", rd, 32'h11BB_33DD);
`endif

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = 32'($urandom_range(0, 15) * 4);
      else if (r == 8) a = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(1, 3));
      else             a = (32'h1000 << $urandom_range(0, 19)) | 32'($urandom_range(0, 15) * 4);
      send(($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0, a, $urandom, 4'($urandom_range(0, 15)));
      get_rsp(($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, rd, er, lat);
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the MIPS core: the memory end of the datapath's dmem interface. It accepts load/store requests (byte address, write data, write flag) through a valid/ready handshake and services them from an internal word-organised SRAM after a programmable number of wait states. It returns read data or a completion/error response through a second valid/ready handshake. It lets the core's load/store path be exercised against a realistic multi-cycle memory instead of an ideal combinational one.

## Interface
- ADDR_W, 10: word-address width; the array holds 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2: wait states between acceptance and memory access; legal range 0–15.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 at a rising edge resets).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address, driven from the ALU result.
- req_wdata  in  32  store data.
- req_strb  in  4  byte-lane write enables; present only with DMEM_BYTE_STROBE_EN.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  request was misaligned or out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch write, addr, wdata and strb.
  - If WAIT_CYCLES>0, load the countdown with WAIT_CYCLES and go to WAIT. Otherwise go to RESP.
- WAIT:
  - req_ready=0.
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to RESP on the next edge.
- Memory access happens on the edge that enters RESP:
  - Load: array word captured into rsp_rdata.
  - Store: write to the array; rsp_rdata=0.
- Error check is done on the latched address:
  - Error if addr[1:0]!=0, or if any of addr[31:ADDR_W+2] is nonzero.
  - On error: no array access, rsp_err=1, rsp_rdata=0.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable.
  - On rsp_valid&rsp_ready, go to IDLE.
  - Back-pressure of any length is legal.
- Word index is addr[ADDR_W+1:2].
- Only one request is outstanding at a time. No pipelining and no request queue.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0. Array contents are not reset.
- Request accepted at the edge ending cycle 0:
  - Cycles 1..W are WAIT.
  - rsp_valid rises in cycle W+1. With W=0, in cycle 1.
- Response accepted at the edge ending cycle k: req_ready=1 in cycle k+1.
  - Minimum period between acceptances is W+2 cycles.
- req_ready is a registered function of state only. It never depends combinationally on req_valid.
- Reset mid-operation:
  - In-flight request is dropped.
  - A store still in WAIT is not written.
  - A store already in RESP has already been committed.
- req_valid while not in IDLE is ignored. The requester must hold the request until accepted.
- A back-to-back load after a store to the same address returns the new data.

## Configuration
- DMEM_BYTE_STROBE_EN defined:
  - req_strb port exists.
  - Stores write only lanes with strb[i]=1; lane i = bits 8i+7:8i, little-endian.
  - strb=0 is a successful no-op store.
  - req_strb is ignored for loads.
- Not defined:
  - No req_strb port.
  - Every store writes the full 32-bit word.

## Structure
- Package dmem_pkg holds:
  - FSM state enum typedef (IDLE, WAIT, RESP).
  - Lane count constant (4).
  - Counter width constant (4).
- One sub-module, dmem_array: single-port synchronous RAM.
  - 2^ADDR_W x 32, write-first read, per-lane write enable.
  - Lane enables are tied to 4'hF when DMEM_BYTE_STROBE_EN is absent.
- FSM, counter, address check and response registers live in dmem_responder.

## Test plan
- Reset, then idle: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Store 0xDEADBEEF to 0x10, then load 0x10, WAIT_CYCLES=2:
  - Each rsp_valid rises exactly 3 cycles after acceptance.
  - Load returns 0xDEADBEEF with rsp_err=0.
- Load from 0x0000_0006 (misaligned) and from 0x0000_1000 (out of range, ADDR_W=10):
  - rsp_err=1, rsp_rdata=0.
  - Array is unchanged; a later load of 0x0 still returns its prior value.
- rsp_ready held low for 5 cycles in RESP:
  - rsp_valid, rsp_rdata and rsp_err stay stable.
  - req_ready stays 0; a new req_valid is not accepted until the cycle after the handshake.
- Store to 0x20, with rst pulsed low during the WAIT cycle:
  - After reset, a load of 0x20 returns the pre-store value.
  - Outputs show reset values.
- With DMEM_BYTE_STROBE_EN: word 0x11223344 at 0x0, then store 0xAABBCCDD with strb=4'b0101 → load returns 0x11BB33DD. With WAIT_CYCLES=0, the response arrives 1 cycle after acceptance.
